// File: rtl/n64_bit_encoder.sv
// Pulse-width line encoder: pulls bits from an upstream serializer and drives
// the one-wire controller line with 4-unit bit cells followed by a 2-unit stop bit.
module n64_bit_encoder #(
   parameter int UNIT_CYCLES = 24,
   parameter int COUNT_WIDTH = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic bit_request,
   input  logic bit_strobe,
   input  logic bit_data,
   output logic tx_drive,
   output logic busy,
   output logic done
);

   localparam logic [COUNT_WIDTH-1:0] LEN1 = COUNT_WIDTH'(UNIT_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] LEN2 = COUNT_WIDTH'(2 * UNIT_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] LEN3 = COUNT_WIDTH'(3 * UNIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, STOP} state_t;

   state_t                 state, state_n;
   logic [COUNT_WIDTH-1:0] cnt, cnt_n;
   logic                   cur, cur_n;
   logic                   have_next, have_next_n;
   logic                   next_bit, next_bit_n;
   logic                   sample;
   logic                   req_n, busy_n, done_n, tx_n;
   logic                   avail, avail_data;

   // sample marks the one cycle after a request in which upstream answers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         cur         <= 1'b0;
         have_next   <= 1'b0;
         next_bit    <= 1'b0;
         sample      <= 1'b0;
         bit_request <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         tx_drive    <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         cur         <= cur_n;
         have_next   <= have_next_n;
         next_bit    <= next_bit_n;
         sample      <= bit_request;
         bit_request <= req_n;
         busy        <= busy_n;
         done        <= done_n;
         tx_drive    <= tx_n;
      end
   end

   // With U=2 the answer arrives on HIGH's last cycle, so bypass the latch
   assign avail      = sample ? bit_strobe : have_next;
   assign avail_data = sample ? bit_data   : next_bit;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cur_n       = cur;
      have_next_n = have_next;
      next_bit_n  = next_bit;
      req_n       = 1'b0;
      busy_n      = busy;
      done_n      = 1'b0;
      if (sample) begin
         have_next_n = bit_strobe;
         next_bit_n  = bit_data;
      end
      case (state)
         IDLE: begin
            if (start) begin
               req_n   = 1'b1;
               busy_n  = 1'b1;
               state_n = FETCH;
            end
         end
         FETCH: begin
            if (sample) begin
               if (bit_strobe) begin
                  cur_n   = bit_data;
                  cnt_n   = bit_data ? LEN1 : LEN3;
                  state_n = LOW;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
               end
            end
         end
         LOW: begin
            if (cnt == '0) begin
               state_n     = HIGH;
               cnt_n       = cur ? LEN3 : LEN1;
               req_n       = 1'b1;
               have_next_n = 1'b0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         HIGH: begin
            if (cnt == '0) begin
               if (avail) begin
                  cur_n   = avail_data;
                  cnt_n   = avail_data ? LEN1 : LEN3;
                  state_n = LOW;
               end else begin
                  cnt_n   = LEN2;
                  state_n = STOP;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         STOP: begin
            if (cnt == '0) begin
               state_n = IDLE;
               done_n  = 1'b1;
               busy_n  = 1'b0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      tx_n = (state_n == LOW) || (state_n == STOP);
   end

endmodule

// File: tb/tb_n64_bit_encoder.sv
// Bench for n64_bit_encoder: upstream serializer model plus a cycle-level
// expectation of the line waveform derived from the bit-cell timing rules.
module tb_n64_bit_encoder;

   localparam int U = 4;

   logic clk = 1'b0;
   logic reset, start, bit_strobe, bit_data;
   logic bit_request, tx_drive, busy, done;

   int passed = 0;
   int total  = 0;

   logic bitq[$];
   logic rq;

   n64_bit_encoder #(.UNIT_CYCLES(U), .COUNT_WIDTH(7)) dut (
      .clk(clk), .reset(reset), .start(start),
      .bit_request(bit_request), .bit_strobe(bit_strobe), .bit_data(bit_data),
      .tx_drive(tx_drive), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, k, obs, exp);
   endtask

   // Expected line level at cycle k of a frame started at cycle 0
   function automatic logic exp_tx(input logic [63:0] bits, input int n, input int k);
      int j, off, lowlen;
      if (n == 0 || k < 3) return 1'b0;
      if (k < 3 + 4*U*n) begin
         j      = (k - 3) / (4*U);
         off    = (k - 3) % (4*U);
         lowlen = bits[n-1-j] ? U : 3*U;
         return off < lowlen;
      end
      return k < 3 + 4*U*n + 2*U;
   endfunction

   // hold: start also high in the done cycle (next frame finds upstream empty)
   // rst_at: reset asserted in that cycle, frame abandoned afterwards
   task automatic run_frame(input string tag, input logic [63:0] bits, input int n,
                            input bit spur, input bit extra, input bit hold, input int rst_at);
      int d, last, reqs;
      logic e_tx, e_busy, e_done;
      d    = (n == 0) ? 3 : 3 + 4*U*n + 2*U;
      last = (rst_at >= 0) ? rst_at + 10 : (hold ? d + 3 : d + 3);
      bitq.delete();
      for (int i = 0; i < n; i++) bitq.push_back(bits[n-1-i]);
      reqs = 0;
      for (int k = 0; k <= last; k++) begin
         start = (k == 0) || (extra && (k == 10 || k == 50)) || (hold && k == d);
         reset = (k == rst_at);
         if (rst_at >= 0 && k > rst_at) begin
            e_tx = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         end else begin
            e_tx   = exp_tx(bits, n, k);
            e_busy = (k >= 1 && k < d) || (hold && k >= d + 1 && k < d + 3);
            e_done = (k == d) || (hold && k == d + 3);
         end
         chk({tag, " tx_drive"}, k, 32'(tx_drive), 32'(e_tx));
         chk({tag, " busy"},     k, 32'(busy),     32'(e_busy));
         chk({tag, " done"},     k, 32'(done),     32'(e_done));
         if (k == 1) chk({tag, " first request"}, k, 32'(bit_request), 32'd1);
         if (bit_request) reqs++;
         rq = bit_request;
         @(posedge clk); #1;
         if (rq) begin
            if (bitq.size() > 0) begin bit_strobe = 1'b1; bit_data = bitq.pop_front(); end
            else begin bit_strobe = 1'b0; bit_data = 1'($urandom); end
         end else begin
            bit_strobe = spur ? 1'($urandom) : 1'b0;
            bit_data   = 1'($urandom);
         end
      end
      start = 1'b0;
      reset = 1'b0;
      if (rst_at < 0) chk({tag, " request count"}, last, 32'(reqs), 32'(n + 1 + (hold ? 1 : 0)));
   endtask

   initial begin
      logic [63:0] rbits;
      int          rn;
      reset = 1'b1; start = 1'b0; bit_strobe = 1'b0; bit_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset tx_drive",    0, 32'(tx_drive),    32'd0);
      chk("reset busy",        0, 32'(busy),        32'd0);
      chk("reset done",        0, 32'(done),        32'd0);
      chk("reset bit_request", 0, 32'(bit_request), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_frame("single 0x80",  64'h80,   8,  1'b0, 1'b0, 1'b0, -1);
      run_frame("b2b FF00",     64'hFF00, 16, 1'b0, 1'b0, 1'b0, -1);
      run_frame("empty",        64'h0,    0,  1'b0, 1'b0, 1'b0, -1);
      run_frame("start busy",   64'h3C,   8,  1'b0, 1'b1, 1'b0, -1);
      run_frame("spurious 55",  64'h55,   8,  1'b1, 1'b0, 1'b0, -1);
      run_frame("mid reset",    64'hA5,   8,  1'b0, 1'b0, 1'b0, 36);
      run_frame("after reset",  64'hC3,   8,  1'b0, 1'b0, 1'b0, -1);
      run_frame("hold start",   64'h2,    2,  1'b0, 1'b0, 1'b1, -1);
      for (int r = 0; r < 4; r++) begin
         rn    = int'($urandom_range(1, 12));
         rbits = {$urandom, $urandom};
         run_frame("random", rbits, rn, 1'b1, 1'b0, 1'b0, -1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
